// File: rtl/msk_g16inv_seq.sv
// Masked GF(16) inverter sequencer: y = x^14 over d shares, 0 -> 0.
// The squarings x^2, x^4, x^8 are taken share by share. The two products
// x^2*x^4 and x^6*x^8 are formed by an external 1-cycle masked multiplier
// gadget, which this block drives and reads back.
// All outputs come straight from flops, so the gadget operands are glitch-free.
// Optional build macro: MSKG16INV_CLEAR_EN clears every data register on the
// output handshake, so no stale shares survive into the next inversion.

`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_g16inv_seq #(
    parameter int unsigned d = `DEFAULTSHARES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [d-1:0] in_x0,
    input  logic [d-1:0] in_x1,
    input  logic [d-1:0] in_x2,
    input  logic [d-1:0] in_x3,
    output logic [d-1:0] mul_a0,
    output logic [d-1:0] mul_a1,
    output logic [d-1:0] mul_a2,
    output logic [d-1:0] mul_a3,
    output logic [d-1:0] mul_b0,
    output logic [d-1:0] mul_b1,
    output logic [d-1:0] mul_b2,
    output logic [d-1:0] mul_b3,
    output logic [d-1:0] mul_a0_prev,
    output logic [d-1:0] mul_a1_prev,
    output logic [d-1:0] mul_a2_prev,
    output logic [d-1:0] mul_a3_prev,
    input  logic [d-1:0] mul_p0,
    input  logic [d-1:0] mul_p1,
    input  logic [d-1:0] mul_p2,
    input  logic [d-1:0] mul_p3,
    output logic         rnd_req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [d-1:0] out_y0,
    output logic [d-1:0] out_y1,
    output logic [d-1:0] out_y2,
    output logic [d-1:0] out_y3
);

    // One bit-sliced GF(16) sharing: element [k] holds bit k of every share.
    typedef logic [3:0][d-1:0] sh_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL1  = 3'd1,
        S_MUL1W = 3'd2,
        S_MUL2  = 3'd3,
        S_MUL2W = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Frobenius map mod x^4+x+1; bitwise ops keep every share separate.
    function automatic sh_t sq(input sh_t s);
        sh_t c;
        c[0] = s[0] ^ s[2];
        c[1] = s[2];
        c[2] = s[1] ^ s[3];
        c[3] = s[3];
        return c;
    endfunction

    state_t state_q, state_d;
    sh_t    x2_q, x2_d;
    sh_t    x4_q, x4_d;
    sh_t    x8_q, x8_d;
    sh_t    y_q, y_d;
    sh_t    r_q, r_d;
    sh_t    mula_q, mula_d;
    sh_t    mulb_q, mulb_d;
    sh_t    aprev_q;
    logic   rnd_q, rnd_d;
    logic   ov_q, ov_d;
    logic   ir_q, ir_d;

    sh_t    x_in, p_in;
    sh_t    sq1, sq2, sq3;

    // Gather the bit-sliced ports into sharings.
    assign x_in = {in_x3, in_x2, in_x1, in_x0};
    assign p_in = {mul_p3, mul_p2, mul_p1, mul_p0};

    // Share-wise power chain of the incoming sharing.
    assign sq1 = sq(x_in);
    assign sq2 = sq(sq1);
    assign sq3 = sq(sq2);

    // Next-state, next-data and next-output decode.
    always_comb begin
        state_d = state_q;
        x2_d    = x2_q;
        x4_d    = x4_q;
        x8_d    = x8_q;
        y_d     = y_q;
        r_d     = r_q;
        mula_d  = '0;
        mulb_d  = '0;
        rnd_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x2_d    = sq1;
                    x4_d    = sq2;
                    x8_d    = sq3;
                    mula_d  = sq1;
                    mulb_d  = sq2;
                    rnd_d   = 1'b1;
                    state_d = S_MUL1;
                end
            end
            S_MUL1: begin
                state_d = S_MUL1W;
            end
            S_MUL1W: begin
                y_d     = p_in;
                mula_d  = p_in;
                mulb_d  = x8_q;
                rnd_d   = 1'b1;
                state_d = S_MUL2;
            end
            S_MUL2: begin
                state_d = S_MUL2W;
            end
            S_MUL2W: begin
                r_d     = p_in;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
`ifdef MSKG16INV_CLEAR_EN
                    x2_d = '0;
                    x4_d = '0;
                    x8_d = '0;
                    y_d  = '0;
                    r_d  = '0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ir_d = (state_d == S_IDLE);
        ov_d = (state_d == S_DONE);
    end

    // State, data and output registers; reset aborts any inversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x2_q    <= '0;
            x4_q    <= '0;
            x8_q    <= '0;
            y_q     <= '0;
            r_q     <= '0;
            mula_q  <= '0;
            mulb_q  <= '0;
            aprev_q <= '0;
            rnd_q   <= 1'b0;
            ov_q    <= 1'b0;
            ir_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            x2_q    <= x2_d;
            x4_q    <= x4_d;
            x8_q    <= x8_d;
            y_q     <= y_d;
            r_q     <= r_d;
            mula_q  <= mula_d;
            mulb_q  <= mulb_d;
            aprev_q <= mula_q;
            rnd_q   <= rnd_d;
            ov_q    <= ov_d;
            ir_q    <= ir_d;
        end
    end

    // Scatter the registered sharings onto the bit-sliced ports.
    assign in_ready    = ir_q;
    assign out_valid   = ov_q;
    assign rnd_req     = rnd_q;

    assign mul_a0      = mula_q[0];
    assign mul_a1      = mula_q[1];
    assign mul_a2      = mula_q[2];
    assign mul_a3      = mula_q[3];
    assign mul_b0      = mulb_q[0];
    assign mul_b1      = mulb_q[1];
    assign mul_b2      = mulb_q[2];
    assign mul_b3      = mulb_q[3];
    assign mul_a0_prev = aprev_q[0];
    assign mul_a1_prev = aprev_q[1];
    assign mul_a2_prev = aprev_q[2];
    assign mul_a3_prev = aprev_q[3];
    assign out_y0      = r_q[0];
    assign out_y1      = r_q[1];
    assign out_y2      = r_q[2];
    assign out_y3      = r_q[3];

endmodule

// File: tb/tb_msk_g16inv_seq.sv
// Bench for msk_g16inv_seq (d=2) with a behavioural 1-cycle masked multiplier.
// Expected inverses come from a hand-computed table and are queued on every
// accept. A negedge monitor checks each result on its handshake.

module tb_msk_g16inv_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_x0, in_x1, in_x2, in_x3;
    logic [1:0] mul_a0, mul_a1, mul_a2, mul_a3;
    logic [1:0] mul_b0, mul_b1, mul_b2, mul_b3;
    logic [1:0] mul_a0_prev, mul_a1_prev, mul_a2_prev, mul_a3_prev;
    logic [1:0] mul_p0, mul_p1, mul_p2, mul_p3;
    logic       rnd_req;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_y0, out_y1, out_y2, out_y3;

    msk_g16inv_seq #(.d(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3),
        .mul_a0(mul_a0), .mul_a1(mul_a1), .mul_a2(mul_a2), .mul_a3(mul_a3),
        .mul_b0(mul_b0), .mul_b1(mul_b1), .mul_b2(mul_b2), .mul_b3(mul_b3),
        .mul_a0_prev(mul_a0_prev), .mul_a1_prev(mul_a1_prev),
        .mul_a2_prev(mul_a2_prev), .mul_a3_prev(mul_a3_prev),
        .mul_p0(mul_p0), .mul_p1(mul_p1), .mul_p2(mul_p2), .mul_p3(mul_p3),
        .rnd_req(rnd_req),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y0(out_y0), .out_y1(out_y1), .out_y2(out_y2), .out_y3(out_y3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] y;
        int         acc;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] inv_tbl [16];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] mp;

    // GF(16) product mod x^4+x+1, used only by the multiplier model.
    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] t;
        r = 4'h0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ t;
            t = t[3] ? ({t[2:0], 1'b0} ^ 4'h3) : {t[2:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [3:0] recomb(input logic [1:0] b3, input logic [1:0] b2,
                                          input logic [1:0] b1, input logic [1:0] b0);
        return {^b3, ^b2, ^b1, ^b0};
    endfunction

    // Returns {share1, share0} of the product, freshly masked every call.
    function automatic logic [7:0] mulmodel(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        r = 4'($urandom);
        return {gmul(a, b) ^ r, r};
    endfunction

    always @(posedge clk)
        mp <= mulmodel(recomb(mul_a3, mul_a2, mul_a1, mul_a0),
                       recomb(mul_b3, mul_b2, mul_b1, mul_b0));

    assign mul_p0 = {mp[4], mp[0]};
    assign mul_p1 = {mp[5], mp[1]};
    assign mul_p2 = {mp[6], mp[2]};
    assign mul_p3 = {mp[7], mp[3]};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_x(input logic [3:0] x);
        logic [3:0] s0;
        logic [3:0] s1;
        s0 = 4'($urandom);
        s1 = x ^ s0;
        in_x0 = {s1[0], s0[0]};
        in_x1 = {s1[1], s0[1]};
        in_x2 = {s1[2], s0[2]};
        in_x3 = {s1[3], s0[3]};
    endtask

    task automatic send(input logic [3:0] x);
        int n;
        exp_t e;
        drive_x(x);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        e.y   = inv_tbl[x];
        e.acc = cyc + 1;
        exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
        drive_x(4'($urandom));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_rnd_req"}, 32'(rnd_req), 32'd0);
        chk({tag, "_mul_a"}, 32'({mul_a3, mul_a2, mul_a1, mul_a0}), 32'd0);
        chk({tag, "_mul_b"}, 32'({mul_b3, mul_b2, mul_b1, mul_b0}), 32'd0);
        chk({tag, "_mul_a_prev"},
            32'({mul_a3_prev, mul_a2_prev, mul_a1_prev, mul_a0_prev}), 32'd0);
        chk({tag, "_out_y"}, 32'({out_y3, out_y2, out_y1, out_y0}), 32'd0);
    endtask

    // Monitor: result/latency on each output, rnd_req schedule, mul_a_prev lag.
    logic       prev_ov;
    logic [7:0] prev_mula;
    logic [5:0] hist;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov   = 1'b0;
            prev_mula = 8'h00;
            hist      = 6'h00;
        end else begin
            chk("mul_a_prev", 32'({mul_a3_prev, mul_a2_prev, mul_a1_prev, mul_a0_prev}),
                32'(prev_mula));
            prev_mula = {mul_a3, mul_a2, mul_a1, mul_a0};
            hist = {hist[4:0], rnd_req};
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("latency", 32'(cyc - exp_q[0].acc), 32'd4);
                    chk("rnd_pattern", 32'(hist), 32'b010100);
                end
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                chk("result", 32'(recomb(out_y3, out_y2, out_y1, out_y0)), 32'(exp_q[0].y));
                void'(exp_q.pop_front());
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;

        // Hand-computed inverses in GF(2)[x]/(x^4+x+1).
        inv_tbl[0]  = 4'h0; inv_tbl[1]  = 4'h1; inv_tbl[2]  = 4'h9; inv_tbl[3]  = 4'hE;
        inv_tbl[4]  = 4'hD; inv_tbl[5]  = 4'hB; inv_tbl[6]  = 4'h7; inv_tbl[7]  = 4'h6;
        inv_tbl[8]  = 4'hF; inv_tbl[9]  = 4'h2; inv_tbl[10] = 4'hC; inv_tbl[11] = 4'h5;
        inv_tbl[12] = 4'hA; inv_tbl[13] = 4'h4; inv_tbl[14] = 4'h3; inv_tbl[15] = 4'h8;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive_x(4'h0);
        tick();
        tick();
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("post_reset");

        // Directed: 0x2 -> 0x9, 0x3 -> 0xE, then the 0 and 1 corner values.
        send(4'h2);
        send(4'h3);
        send(4'h0);
        send(4'h1);
        drain();

        // Every field element, ten random sharings each, back to back.
        for (int x = 0; x < 16; x++)
            for (int k = 0; k < 10; k++)
                send(4'(x));
        drain();

        // Consumer stall: output must hold, in_ready low, in_valid ignored.
        out_ready = 1'b0;
        send(4'h5);
        wait_valid();
        held = {out_y3, out_y2, out_y1, out_y0};
        for (int i = 0; i < 7; i++) begin
            drive_x(4'h9);
            in_valid = 1'b1;
            tick();
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_y", 32'({out_y3, out_y2, out_y1, out_y0}), 32'(held));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        tick();
        chk("stall_no_extra", 32'(out_valid), 32'd0);

        // Reset during MUL2 aborts the inversion.
        send(4'hB);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        void'(exp_q.pop_front());
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        send(4'hC);
        drain();

        // Register contents after the handshake.
        send(4'h7);
        wait_valid();
        tick();
`ifdef MSKG16INV_CLEAR_EN
        chk("clear_out_y", 32'({out_y3, out_y2, out_y1, out_y0}), 32'd0);
`else
        chk("retain_out_y", 32'(recomb(out_y3, out_y2, out_y1, out_y0)), 32'h6);
`endif
        drain();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
